// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing constants for the HC-SR04 measurement sequencer.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } us_state_t;

  localparam int DEF_CLK_PER_US = 27;
  localparam int DEF_TRIG_US    = 10;
  localparam int DEF_TIMEOUT_US = 30000;
  localparam int DEF_PERIOD_US  = 60000;

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: counts 0..CLK_PER_US-1 and flags the terminal count.
// A synchronous clr restarts the count so tick phase aligns with the caller's event.
module us_tick_gen
  import ultrasonic_pkg::*;
#(
  parameter int CLK_PER_US = DEF_CLK_PER_US
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic us_tick
);

  localparam int            W    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [W-1:0]  TERM = W'(CLK_PER_US - 1);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign us_tick = (cnt == TERM);

endmodule

// File: rtl/ultrasonic_ctrl.sv
// HC-SR04 sequencer: fires the trigger, times the synchronized echo in microseconds,
// and repeats on a fixed trigger-to-trigger period with an echo timeout.
module ultrasonic_ctrl
  import ultrasonic_pkg::*;
#(
  parameter int CLK_PER_US = DEF_CLK_PER_US,
  parameter int TRIG_US    = DEF_TRIG_US,
  parameter int TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int PERIOD_US  = DEF_PERIOD_US
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] measure,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  us_state_t   state;
  logic        echo_meta, echo_s, echo_prev;
  logic        rise, fall;
  logic [15:0] per_cnt, wid_cnt, wid_next;
  logic        per_tick, wid_tick;
  logic        clr_per, clr_wid;
  logic        trig_end, to_end, period_end;

  // Period and width use separate prescalers so restarting the width phase on MEASURE
  // entry never disturbs the trigger-to-trigger period.
  us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_per_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_per),
    .us_tick (per_tick)
  );

  us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_wid_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_wid),
    .us_tick (wid_tick)
  );

  assign rise = echo_s && !echo_prev;
  assign fall = !echo_s && echo_prev;

  // Limits fire on the tick that moves per_cnt onto the limit, so the transition edge
  // coincides with per_cnt reaching it.
  assign trig_end   = per_tick && (per_cnt == 16'(TRIG_US - 1));
  assign to_end     = per_tick && (per_cnt == 16'(TIMEOUT_US - 1));
  assign period_end = per_tick && (per_cnt == 16'(PERIOD_US - 1));

  assign clr_per = en && ((state == IDLE) || ((state == HOLDOFF) && period_end));
  assign clr_wid = (state == WAIT_RISE) && rise && !to_end;

  // Includes the tick of the current cycle so a fall latches the full floor(high/CLK_PER_US).
  assign wid_next = (wid_tick && (wid_cnt != 16'hFFFF)) ? wid_cnt + 16'd1 : wid_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
      echo_prev <= 1'b0;
      per_cnt   <= '0;
      wid_cnt   <= '0;
    end else begin
      echo_meta <= echo;
      echo_s    <= echo_meta;
      echo_prev <= echo_s;

      if (clr_per) begin
        per_cnt <= '0;
      end else if ((state != IDLE) && per_tick) begin
        per_cnt <= per_cnt + 16'd1;
      end

      if (clr_wid) begin
        wid_cnt <= '0;
      end else if (state == MEASURE) begin
        wid_cnt <= wid_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      trig    <= 1'b0;
      measure <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      busy    <= 1'b0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state <= TRIG;
            trig  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        TRIG: begin
          if (trig_end) begin
            state <= WAIT_RISE;
            trig  <= 1'b0;
          end
        end
        WAIT_RISE: begin
          if (to_end) begin
            timeout <= 1'b1;
            state   <= HOLDOFF;
          end else if (rise) begin
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (to_end) begin
            timeout <= 1'b1;
            state   <= HOLDOFF;
          end else if (fall) begin
            measure <= wid_next;
            valid   <= 1'b1;
            state   <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (period_end) begin
            if (en) begin
              state <= TRIG;
              trig  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          trig  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_ctrl.sv
// Scoreboard bench for ultrasonic_ctrl: stimulus pushes expected trigger/result events,
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_ultrasonic_ctrl;

  localparam int CPU      = 4;
  localparam int TRIG_US  = 10;
  localparam int TO_US    = 100;
  localparam int PER_US   = 200;
  localparam int TRIG_CYC = TRIG_US * CPU;
  localparam int TO_CYC   = TO_US * CPU;
  localparam int PER_CYC  = PER_US * CPU;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        echo = 1'b0;
  logic        trig, valid, timeout, busy;
  logic [15:0] measure;

  ultrasonic_ctrl #(
    .CLK_PER_US (CPU),
    .TRIG_US    (TRIG_US),
    .TIMEOUT_US (TO_US),
    .PERIOD_US  (PER_US)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .echo    (echo),
    .trig    (trig),
    .measure (measure),
    .valid   (valid),
    .timeout (timeout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_TRIG_RISE, EV_TRIG_FALL, EV_VALID, EV_TIMEOUT} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       meas;
  } ev_t;

  ev_t  sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_meas   = 0;
  logic trig_q      = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input int c, input int m);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.meas = m;
    sb.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k);
    ev_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event %s at cycle %0d: got event, required none", k.name(), cyc);
    end else begin
      e = sb.pop_front();
      check($sformatf("event_kind(exp %s)", e.kind.name()), int'(k), int'(e.kind));
      check($sformatf("%s_cycle", k.name()), cyc, e.cyc);
      if (k == EV_VALID || k == EV_TIMEOUT)
        check($sformatf("%s_measure", k.name()), int'(measure), e.meas);
    end
  endtask

  always @(negedge clk) begin
    if (trig === 1'b1 && trig_q === 1'b0) observe(EV_TRIG_RISE);
    if (trig === 1'b0 && trig_q === 1'b1) observe(EV_TRIG_FALL);
    if (valid === 1'b1)   observe(EV_VALID);
    if (timeout === 1'b1) observe(EV_TIMEOUT);
    trig_q = trig;
  end

  // One measurement cycle starting in the first trig-high cycle. Echo pin is high for
  // cycles [p, p+h) relative to that; p < 0 means no echo. mode 0: continuous,
  // mode 1: en dropped mid-cycle, mode 2: rst pulsed during MEASURE.
  task automatic run_period(input int p, input int h, input int mode);
    int t0, a, b, drop;
    t0 = cyc;
    expect_ev(EV_TRIG_RISE, t0, 0);
    expect_ev(EV_TRIG_FALL, t0 + TRIG_CYC, 0);
    if (mode == 2) begin
      last_meas = 0;
    end else if (p < 0) begin
      expect_ev(EV_TIMEOUT, t0 + TO_CYC, last_meas);
    end else begin
      // echo_s is high over cycles [a, b); edge must be seen while waiting and the
      // fall must register before the timeout edge.
      a = p + 2;
      b = p + h + 2;
      if (a >= TRIG_CYC && b + 1 < TO_CYC) begin
        last_meas = (b - a) / CPU;
        expect_ev(EV_VALID, t0 + b + 1, last_meas);
      end else begin
        expect_ev(EV_TIMEOUT, t0 + TO_CYC, last_meas);
      end
    end
    drop = (p >= 0) ? p + 5 : 50;
    for (int c = 0; c < PER_CYC; c++) begin
      if (mode == 2 && c == 150) begin
        rst = 1'b1;
        en  = 1'b0;
      end
      if (mode == 2 && c == 151) begin
        rst = 1'b0;
        check("rst_mid_trig", int'(trig), 0);
        check("rst_mid_measure", int'(measure), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_valid", int'(valid), 0);
      end
      if (mode == 1 && c == drop) en = 1'b0;
      if (mode == 1 && c == PER_CYC - 1) check("busy_before_idle", int'(busy), 1);
      echo = (p >= 0 && c >= p && c < p + h);
      @(posedge clk);
      #1;
    end
    echo = 1'b0;
    if (mode == 1) begin
      check("busy_after_period", int'(busy), 0);
      check("trig_after_period", int'(trig), 0);
    end
  endtask

  task automatic restart();
    en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1);
  end

  initial begin
    int p, h, kind;
    rst  = 1'b1;
    en   = 1'b1;
    echo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_trig", int'(trig), 0);
    check("reset_measure", int'(measure), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_timeout", int'(timeout), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("busy_after_start", int'(busy), 1);

    run_period(80, 200, 0);   // 50 us echo
    run_period(-1, 0, 0);     // no echo: timeout, measure held
    run_period(80, 600, 0);   // 150 us echo: timeout, late fall ignored
    run_period(38, 358, 0);   // earliest visible rise, latest accepted fall
    run_period(38, 359, 0);   // fall one cycle too late
    run_period(37, 100, 0);   // echo already high when trigger ends
    run_period(80, 200, 1);   // en dropped during MEASURE

    repeat (100) @(posedge clk);
    #1;
    restart();
    run_period(80, 200, 2);   // rst pulsed during MEASURE
    restart();

    for (int i = 0; i < 16; i++) begin
      kind = int'($urandom_range(3, 0));
      case (kind)
        0: begin
          p = int'($urandom_range(300, 38));
          h = int'($urandom_range(396 - p, 1));
        end
        1: begin
          p = -1;
          h = 0;
        end
        2: begin
          p = int'($urandom_range(37, 0));
          h = int'($urandom_range(700, 1));
        end
        default: begin
          p = int'($urandom_range(300, 38));
          h = int'($urandom_range(780 - p, 397 - p));
        end
      endcase
      run_period(p, h, (i == 15) ? 1 : 0);
    end

    repeat (50) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
